// File: rtl/fads_sort_sequencer.sv
// FADS sort sequencer: delays classifier sort triggers by the droplet travel time
// and issues fixed-width, holdoff-spaced trigger pulses to the ASG.
module fads_sort_sequencer #(
    parameter int QSZ = 3,
    parameter int TSW = 32
) (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    input  logic        sort_trig_i,
    output logic        asg_trig_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);
    localparam int DEPTH = 1 << QSZ;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state;
    logic [TSW-1:0] ts, cnt;
    logic [TSW-1:0] delay, width, holdoff;
    logic           enable;
    logic [31:0]    issued, dropped;
    logic           trig_q, req_q, due_q;
    logic [TSW-1:0] mem [DEPTH];
    logic [QSZ-1:0] rd_ptr, wr_ptr;
    logic [QSZ:0]   fill;

    logic [19:0]    addr;
    logic           ctrl_wr, flush, clr_cnt;
    logic           pop, push, drop, full, head_due;
    logic [TSW-1:0] head_diff, width_m1;
    logic [31:0]    status, rd_val;
    logic           unused_bits;

    assign addr        = sys_addr[19:0];
    assign unused_bits = ^{sys_sel, sys_addr[31:20]};
    assign sys_err     = 1'b0;

    assign ctrl_wr  = sys_wen && (addr == 20'h0000C);
    assign flush    = ctrl_wr && sys_wdata[1];
    assign clr_cnt  = ctrl_wr && sys_wdata[2];

    // Wrap-safe due test: head is due once the signed distance ts - head is >= 0.
    assign head_diff = ts - mem[rd_ptr];
    assign head_due  = (fill != '0) && !head_diff[TSW-1];
    assign pop       = (state == IDLE) && (fill != '0) && due_q;
    assign full      = (fill == (QSZ+1)'(DEPTH)) && !pop;
    assign push      = req_q && enable && !full && !flush;
    assign drop      = req_q && enable && full;
    assign width_m1  = (width == '0) ? '0 : width - 1'b1;

    always_comb begin
        status        = '0;
        status[QSZ:0] = fill;
        status[17:16] = state;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            20'h00000: rd_val = 32'(delay);
            20'h00004: rd_val = 32'(width);
            20'h00008: rd_val = 32'(holdoff);
            20'h0000C: rd_val = {31'b0, enable};
            20'h00010: rd_val = issued;
            20'h00014: rd_val = dropped;
            20'h00018: rd_val = status;
            default:   rd_val = '0;
        endcase
    end

    // Trigger front end: registered edge detect, so the push lands one cycle after sampling.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            ts     <= '0;
            trig_q <= 1'b0;
            req_q  <= 1'b0;
            due_q  <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            ts     <= ts + 1'b1;
            trig_q <= sort_trig_i;
            req_q  <= sort_trig_i && !trig_q;
            due_q  <= head_due;
            busy_o <= (fill != '0) || (state != IDLE);
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (push) mem[wr_ptr] <= ts + delay;
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + {{QSZ{1'b0}}, push} - {{QSZ{1'b0}}, pop};
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state      <= IDLE;
            cnt        <= '0;
            asg_trig_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    asg_trig_o <= 1'b1;
                    cnt        <= width_m1;
                    state      <= PULSE;
                end
                PULSE: if (cnt == '0) begin
                    asg_trig_o <= 1'b0;
                    if (holdoff == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= holdoff - 1'b1;
                        state <= HOLD;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                HOLD: if (cnt == '0) state <= IDLE;
                      else           cnt   <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating event counters; a clear strobe beats a same-cycle increment.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            issued  <= '0;
            dropped <= '0;
        end else if (clr_cnt) begin
            issued  <= '0;
            dropped <= '0;
        end else begin
            if (pop  && issued  != '1) issued  <= issued + 1'b1;
            if (drop && dropped != '1) dropped <= dropped + 1'b1;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            delay     <= TSW'(1000);
            width     <= TSW'(125);
            holdoff   <= '0;
            enable    <= 1'b0;
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack <= sys_wen | sys_ren;
            if (sys_ren) sys_rdata <= rd_val;
            if (sys_wen) begin
                case (addr)
                    20'h00000: delay   <= sys_wdata[TSW-1:0];
                    20'h00004: width   <= sys_wdata[TSW-1:0];
                    20'h00008: holdoff <= sys_wdata[TSW-1:0];
                    20'h0000C: enable  <= sys_wdata[0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fads_sort_sequencer.sv
// Scoreboard bench for fads_sort_sequencer: a cycle-level reference model predicts
// each pulse's rise edge and width; a monitor checks every observed pulse.
module tb_fads_sort_sequencer;
    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        trig = 1'b0;
    logic        wen  = 1'b0;
    logic        ren  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel   = 4'hF;
    logic        asg, busy, err, ack;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    fads_sort_sequencer dut (
        .adc_clk_i(clk), .adc_rstn_i(rstn), .sort_trig_i(trig),
        .asg_trig_o(asg), .busy_o(busy),
        .sys_addr(addr), .sys_wdata(wdata), .sys_sel(sel),
        .sys_wen(wen), .sys_ren(ren),
        .sys_rdata(rdata), .sys_err(err), .sys_ack(ack)
    );

    typedef struct { int rise; int width; } exp_t;
    exp_t exp_q[$];
    int   fire_q[$];
    int   total = 0, passed = 0, cyc = 0, seen = 0;
    int   last_rise = -1000000;
    int   m_delay = 1000, m_width = 125, m_hold = 0;
    int   m_issued = 0, m_dropped = 0;
    bit   m_en = 1'b0, mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: trigger first sampled at edge n. A request is accepted if
    // fewer than 8 earlier requests are still waiting at its push edge (n+1);
    // it fires at n+DELAY+2, or later if the previous pulse and holdoff still run.
    function automatic void model_req(input int n);
        int p, w, fire;
        exp_t e;
        if (!m_en) return;
        p = n + 1;
        w = (m_width == 0) ? 1 : m_width;
        while (fire_q.size() > 0 && fire_q[0] <= p) void'(fire_q.pop_front());
        if (fire_q.size() >= 8) begin
            m_dropped++;
            return;
        end
        fire = n + m_delay + 2;
        if (last_rise + w + m_hold + 1 > fire) fire = last_rise + w + m_hold + 1;
        last_rise = fire;
        fire_q.push_back(fire);
        m_issued++;
        e.rise  = fire;
        e.width = w;
        exp_q.push_back(e);
    endfunction

    initial begin : monitor
        logic prev;
        int   rise_at, cur_w;
        exp_t e;
        prev = 1'b0; rise_at = 0; cur_w = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (asg && !prev) begin
                    rise_at = cyc;
                    seen++;
                    check("pulse_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("pulse_rise_edge", rise_at, e.rise);
                        cur_w = e.width;
                    end
                end
                if (!asg && prev) check("pulse_width", cyc - rise_at, cur_w);
            end
            prev = asg;
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); addr = a; wdata = d; wen = 1'b1;
        @(negedge clk); wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic k);
        @(negedge clk); addr = a; ren = 1'b1;
        @(negedge clk); ren = 1'b0; d = rdata; k = ack;
    endtask

    task automatic set_regs(input int d, input int w, input int h, input bit en);
        bus_wr(32'h00, 32'(d)); bus_wr(32'h04, 32'(w));
        bus_wr(32'h08, 32'(h)); bus_wr(32'h0C, {31'b0, en});
        m_delay = d; m_width = w; m_hold = h; m_en = en;
    endtask

    task automatic fire_trig(input int hi, input bit model);
        @(negedge clk);
        trig = 1'b1;
        if (model) model_req(cyc + 1);
        repeat (hi) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || asg) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", n < budget, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_asg(input int budget);
        int n = 0;
        while (!asg && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen_in_budget", n < budget, 1);
    endtask

    task automatic check_counts();
        logic [31:0] d;
        logic k;
        bus_rd(32'h10, d, k); check("issued", d, m_issued);
        bus_rd(32'h14, d, k); check("dropped", d, m_dropped);
        check("pulses_observed", seen, m_issued);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        logic k;

        repeat (3) @(negedge clk);
        check("reset_asg", asg, 0);
        check("reset_busy", busy, 0);
        check("reset_ack", ack, 0);
        check("reset_rdata", rdata, 0);
        rstn = 1'b1;
        bus_rd(32'h00, d, k); check("default_delay", d, 1000);
        bus_rd(32'h04, d, k); check("default_width", d, 125);
        bus_rd(32'h08, d, k); check("default_holdoff", d, 0);
        bus_rd(32'h0C, d, k); check("default_ctrl", d, 0);

        // Single trigger held high 3 cycles: one pulse of width 5.
        set_regs(10, 5, 0, 1'b1);
        fire_trig(3, 1'b1);
        drain(200);

        // Three triggers 3 cycles apart; holdoff pushes later pulses out.
        set_regs(50, 4, 10, 1'b1);
        for (int i = 0; i < 3; i++) fire_trig(2, 1'b1);
        drain(400);
        check_counts();

        // Overflow: ten triggers 4 cycles apart with a long delay.
        set_regs(1000, 4, 0, 1'b1);
        for (int i = 0; i < 10; i++) fire_trig(3, 1'b1);
        bus_rd(32'h18, d, k); check("status_fill_full", d[3:0], 8);
        drain(3000);
        check_counts();

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            set_regs(int'($urandom_range(5, 60)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 8)), 1'b1);
            for (int i = 0; i < 12; i++) begin
                fire_trig(int'($urandom_range(1, 3)), 1'b1);
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            drain(3000);
            check_counts();
        end

        // Timestamp wrap: delay spans the 2^32 rollover.
        set_regs(40, 3, 0, 1'b1);
        @(negedge clk); force dut.ts = 32'hFFFF_FFEC;
        @(negedge clk); release dut.ts;
        fire_trig(1, 1'b1);
        drain(200);

        // Flush mid-pulse: first pulse completes, the two queued ones vanish.
        set_regs(20, 20, 0, 1'b1);
        fire_trig(1, 1'b1);
        fire_trig(1, 1'b0);
        fire_trig(1, 1'b0);
        wait_asg(200);
        bus_wr(32'h0C, 32'h3);
        drain(300);
        repeat (60) @(negedge clk);
        bus_rd(32'h18, d, k); check("status_fill_after_flush", d[3:0], 0);
        check_counts();

        // Zero width still gives a one-cycle pulse.
        set_regs(8, 0, 0, 1'b1);
        fire_trig(1, 1'b1);
        fire_trig(2, 1'b1);
        drain(200);

        // Disabled: triggers ignored and not counted as dropped.
        set_regs(8, 3, 0, 1'b0);
        for (int i = 0; i < 4; i++) fire_trig(1, 1'b1);
        repeat (100) @(negedge clk);
        check_counts();

        // Unmapped read.
        bus_rd(32'h40, d, k);
        check("unmapped_rdata", d, 0);
        check("unmapped_ack", k, 1);
        check("unmapped_err", err, 0);

        // Counter clear.
        bus_wr(32'h0C, 32'h4);
        m_issued = 0; m_dropped = 0; seen = 0;
        check_counts();

        // Asynchronous reset in the middle of a pulse.
        mon_en = 1'b0;
        set_regs(5, 30, 0, 1'b1);
        fire_trig(1, 1'b0);
        wait_asg(100);
        #2 rstn = 1'b0;
        #1 check("async_reset_asg", asg, 0);
        check("async_reset_busy", busy, 0);
        @(negedge clk); rstn = 1'b1;
        bus_rd(32'h00, d, k); check("reset_again_delay", d, 1000);
        bus_rd(32'h04, d, k); check("reset_again_width", d, 125);
        bus_rd(32'h0C, d, k); check("reset_again_ctrl", d, 0);
        bus_rd(32'h10, d, k); check("reset_again_issued", d, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fads_sort_sequencer.md
Name: fads_sort_sequencer

Overview:
- Sits directly downstream of the FADS droplet classifier.
- Consumes its sort trigger and delays each trigger by the droplet's programmable travel time from detection spot to sorting junction.
- Then emits a fixed-width trigger pulse to the ASG that drives the external HV amplifier.
- Queues triggers for droplets still in transit; enforces a minimum holdoff between pulses; counts issued and dropped sorts on the system bus.

Parameters:
QSZ, 3, log2 depth of in-flight trigger queue (8 entries)
TSW, 32, width of timestamp counter, delay, width and holdoff registers

Ports:
adc_clk_i  in  1  ADC clock, sole clock
adc_rstn_i  in  1  reset, asynchronous, active-low
sort_trig_i  in  1  sort request from classifier, level; rising edge = one request
asg_trig_o  out  1  registered trigger to ASG, high for WIDTH cycles
busy_o  out  1  registered; high when queue non-empty or FSM not IDLE
sys_addr  in  32  bus address
sys_wdata  in  32  bus write data
sys_sel  in  4  byte select (ignored, full-word writes)
sys_wen  in  1  bus write enable
sys_ren  in  1  bus read enable
sys_rdata  out  32  bus read data
sys_err  out  1  bus error, always 0
sys_ack  out  1  bus acknowledge

Behaviour:
- Reset: async assert/sync release. All outputs 0. Queue empty, FSM IDLE, counters 0, ts=0, edge-detect history 0. Registers reset to DELAY=1000, WIDTH=125, HOLDOFF=0, CTRL.enable=0.
- ts: free-running TSW-bit counter; increments every cycle; wraps.
- Edge detect: req = sort_trig_i & ~sort_trig_q (registered previous sample). Only rising edges count; a held-high trigger is one request.
- Push: req & enable & queue not full -> enqueue (ts + DELAY) mod 2^TSW.
- Push dropped: req & enable & full (after same-cycle pop) -> no enqueue, DROPPED += 1. Simultaneous push and pop when full is accepted.
- Due test: head entry is due when (ts - head) mod 2^TSW has MSB = 0, i.e. signed difference >= 0.
  - Strict FIFO order; a later entry with a smaller due time waits for the head, then fires immediately.
- FSM states:
  - IDLE: queue non-empty & head due -> pop, asg_trig_o<=1, cnt<=max(WIDTH,1)-1, go PULSE.
  - PULSE: asg_trig_o held 1. When cnt==0: asg_trig_o<=0; if HOLDOFF==0 go IDLE, else cnt<=HOLDOFF-1, go HOLD. Otherwise cnt--.
  - HOLD: asg_trig_o 0. cnt==0 -> IDLE, else cnt--. Due entries wait; they fire late, never dropped.
- Latency: queue empty, FSM IDLE, trigger first sampled high at edge N -> asg_trig_o rises at edge N+DELAY+2. Pulse lasts exactly max(WIDTH,1) cycles.
- Back-to-back pulses: minimum spacing from rise to rise = max(WIDTH,1)+HOLDOFF+1 cycles.
- ISSUED += 1 on each pop. Counters saturate at 2^32-1; no wrap.
- CTRL.enable=0: new requests ignored (not counted as dropped). Queued entries still drain.
- CTRL.flush (bit1, self-clearing write strobe): empties queue next cycle. An in-progress pulse/holdoff completes.
- Register writes take effect next cycle. DELAY changes do not alter entries already queued.
- Bus: sys_ack registered one cycle after (sys_wen|sys_ren); sys_err always 0. Decode on sys_addr[19:0]; unmapped reads return 0 and are still acked.
- Register map:
  - 0x00 DELAY rw
  - 0x04 WIDTH rw
  - 0x08 HOLDOFF rw
  - 0x0C CTRL rw: bit0 enable, bit1 flush (reads 0), bit2 clear counters (write strobe, reads 0)
  - 0x10 ISSUED ro
  - 0x14 DROPPED ro
  - 0x18 STATUS ro: [QSZ:0] fill level, [17:16] FSM state (IDLE=0, PULSE=1, HOLD=2)
- Clear counters concurrent with an increment: clear wins.

Test Plan:
- DELAY=10, WIDTH=5, HOLDOFF=0, enable; trigger high at edge 100 for 3 cycles -> asg_trig_o high edges 112..116 only; ISSUED=1.
- DELAY=50, WIDTH=4, HOLDOFF=10; triggers at 0, 3, 6 -> rises at 52, 67, 82 (holdoff-delayed); ISSUED=3, DROPPED=0.
- DELAY=1000; 10 rising edges 4 cycles apart -> first 8 queued, DROPPED=2, STATUS fill peaks at 8; exactly 8 pulses follow.
- Preload ts near 2^32-20 (via reset timing or force), DELAY=40 -> pulse rises exactly 42 cycles after trigger across ts wrap.
- 3 triggers queued, write CTRL flush mid-pulse -> current pulse completes full width, no further pulses, fill=0; adc_rstn_i low mid-pulse -> asg_trig_o 0 immediately (async), registers return to defaults.
- WIDTH=0 -> 1-cycle pulse; enable=0 with triggers -> no pulses, DROPPED unchanged; read 0x40 -> ack next cycle, rdata=0, err=0.
